// File: rtl/delay_line_sched.sv
// delay_line_sched: sample-counted delay line over an inferred circular buffer.
// The output is the accepted-sample stream delayed by active_delay samples.
// Delay changes are queued and applied only on a start-of-line strobe, which
// restarts priming so that a line is never built from two different delays.
module delay_line_sched #(
    parameter int DATA_W        = 12,
    parameter int DEPTH         = 1024,
    parameter int ADDR_W        = 10,
    parameter int DEFAULT_DELAY = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     sol,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     cfg_load,
    input  logic        [ADDR_W-1:0] cfg_delay,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     out_valid,
    output logic                     primed,
    output logic                     cfg_pending,
    output logic        [ADDR_W-1:0] active_delay
);

    localparam logic [ADDR_W-1:0] MAX_DELAY = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] RST_DELAY = ADDR_W'(DEFAULT_DELAY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic        [ADDR_W-1:0] wr_ptr_reg;
    logic        [ADDR_W-1:0] fill_cnt_reg;
    logic        [ADDR_W-1:0] active_delay_reg;
    logic        [ADDR_W-1:0] pending_delay_reg;
    logic                     cfg_pending_reg;
    logic signed [DATA_W-1:0] data_out_reg;
    logic                     out_valid_reg;

    logic signed [DATA_W-1:0] mem [DEPTH];

    // A delay of 0 would make the read and write addresses coincide, and
    // DEPTH-1 is the longest history the ring can hold.
    function automatic logic [ADDR_W-1:0] clamp_delay(input logic [ADDR_W-1:0] d);
        if (d == '0)
            return ADDR_W'(1);
        else if (d >= MAX_DELAY)
            return MAX_DELAY;
        else
            return d;
    endfunction

    logic [ADDR_W-1:0] cfg_clamped;
    logic [ADDR_W-1:0] eff_pending;
    logic              eff_pending_valid;
    logic              active_state;
    logic              apply_cfg;
    logic              in_fill;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W-1:0] fill_inc;
    logic [ADDR_W-1:0] delay_now;
    logic              fill_done;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    // Decode this cycle's events; a cfg_load in the sol cycle is applied at once.
    always_comb begin
        cfg_clamped       = clamp_delay(cfg_delay);
        eff_pending       = cfg_load ? cfg_clamped : pending_delay_reg;
        eff_pending_valid = cfg_load | cfg_pending_reg;
        active_state      = enable && (state_reg != IDLE);
        apply_cfg         = active_state && sol && eff_pending_valid;
        in_fill           = active_state && ((state_reg == FILL) || apply_cfg);
        fill_base         = apply_cfg ? '0 : fill_cnt_reg;
        fill_inc          = fill_base + ADDR_W'(1);
        delay_now         = apply_cfg ? eff_pending : active_delay_reg;
        fill_done         = in_fill && in_valid && (fill_inc == delay_now);
        wr_en             = active_state && in_valid;
        rd_en             = active_state && in_valid && (state_reg == RUN) && !apply_cfg;
        rd_addr           = wr_ptr_reg - active_delay_reg;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic; enable low overrides everything, including reconfiguration.
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = FILL;
                FILL,
                RUN: begin
                    if (in_fill)
                        state_next = fill_done ? RUN : FILL;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Status outputs decoded from the registered state and control registers.
    always_comb begin
        primed       = (state_reg == RUN);
        cfg_pending  = cfg_pending_reg;
        active_delay = active_delay_reg;
        data_out     = data_out_reg;
        out_valid    = out_valid_reg;
    end

    // Write pointer and fill counter; both restart whenever the block is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            fill_cnt_reg <= '0;
        end else if (!active_state) begin
            wr_ptr_reg   <= '0;
            fill_cnt_reg <= '0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            if (in_fill)
                fill_cnt_reg <= fill_base + {{(ADDR_W-1){1'b0}}, in_valid};
        end
    end

    // Delay configuration: queue on cfg_load (last wins), apply on sol.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_delay_reg  <= RST_DELAY;
            pending_delay_reg <= RST_DELAY;
            cfg_pending_reg   <= 1'b0;
        end else if (apply_cfg) begin
            active_delay_reg  <= eff_pending;
            cfg_pending_reg   <= 1'b0;
        end else if (cfg_load) begin
            pending_delay_reg <= cfg_clamped;
            cfg_pending_reg   <= 1'b1;
        end
    end

    // Buffer write port; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= data_in;
    end

    // Registered read: one output per accepted sample in RUN, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= rd_en;
            if (rd_en)
                data_out_reg <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_delay_line_sched.sv
// tb_delay_line_sched: randomized and directed stimulus checked every cycle
// against a sample-history reference model of the delay controller.
module tb_delay_line_sched;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int DEF_D  = 8;

    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_RUN  = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     enable = 1'b0;
    logic                     sol = 1'b0;
    logic                     in_valid = 1'b0;
    logic signed [DATA_W-1:0] data_in = '0;
    logic                     cfg_load = 1'b0;
    logic        [ADDR_W-1:0] cfg_delay = '0;
    logic signed [DATA_W-1:0] data_out;
    logic                     out_valid;
    logic                     primed;
    logic                     cfg_pending;
    logic        [ADDR_W-1:0] active_delay;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: every accepted sample since the last FILL entry from IDLE.
    logic [DATA_W-1:0] hist[$];
    int                m_mode;
    int                m_fill;
    int                m_d;
    int                m_pend;
    bit                m_pv;
    logic [DATA_W-1:0] m_out;
    bit                m_ov;

    delay_line_sched dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sol          (sol),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .cfg_load     (cfg_load),
        .cfg_delay    (cfg_delay),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .primed       (primed),
        .cfg_pending  (cfg_pending),
        .active_delay (active_delay)
    );

    always #7 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int d);
        if (d == 0) return 1;
        if (d >= DEPTH - 1) return DEPTH - 1;
        return d;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_mode = M_IDLE;
        m_fill = 0;
        m_d    = DEF_D;
        m_pend = DEF_D;
        m_pv   = 0;
        m_out  = '0;
        m_ov   = 0;
    endtask

    // Apply one clock edge's worth of inputs to the model.
    task automatic model_step(input bit en, input bit s, input bit iv,
                              input logic [DATA_W-1:0] din, input bit cl, input int cd);
        bit applied = 0;
        m_ov = 0;
        if (!en) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_FILL;
            m_fill = 0;
            hist.delete();
        end else begin
            if (s && (cl || m_pv)) begin
                m_d     = cl ? clamp(cd) : m_pend;
                m_pv    = 0;
                m_mode  = M_FILL;
                m_fill  = 0;
                applied = 1;
            end
            if (iv) begin
                if (m_mode == M_FILL) begin
                    hist.push_back(din);
                    m_fill++;
                    if (m_fill == m_d) m_mode = M_RUN;
                end else begin
                    m_out = hist[hist.size() - m_d];
                    hist.push_back(din);
                    m_ov = 1;
                end
            end
        end
        if (cl && !applied) begin
            m_pend = clamp(cd);
            m_pv   = 1;
        end
    endtask

    // One clock cycle: drive, clock, update model, compare all outputs.
    task automatic cyc(input bit en, input bit s, input bit iv,
                       input int din, input bit cl, input int cd);
        enable    = en;
        sol       = s;
        in_valid  = iv;
        data_in   = DATA_W'(din);
        cfg_load  = cl;
        cfg_delay = ADDR_W'(cd);
        @(posedge clk);
        model_step(en, s, iv, DATA_W'(din), cl, cd);
        #1;
        chk("out_valid",    int'(out_valid),   int'(m_ov));
        chk("data_out",     int'(unsigned'(data_out)), int'(m_out));
        chk("primed",       int'(primed),      int'(m_mode == M_RUN));
        chk("cfg_pending",  int'(cfg_pending), int'(m_pv));
        chk("active_delay", int'(active_delay), m_d);
    endtask

    function automatic int rnd_data();
        return int'($urandom_range(0, 4095));
    endfunction

    initial begin
        int first_idx;
        int captured;
        int seen;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid",    int'(out_valid), 0);
        chk("rst_data_out",     int'(data_out), 0);
        chk("rst_primed",       int'(primed), 0);
        chk("rst_cfg_pending",  int'(cfg_pending), 0);
        chk("rst_active_delay", int'(active_delay), DEF_D);

        // Continuous stream 0,10,...,190 with the default delay of 8.
        cyc(1, 0, 0, 0, 0, 0);
        first_idx = -1;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 1, i * 10, 0, 0);
            if (out_valid && first_idx < 0) begin
                first_idx = i;
                chk("first_out_value", int'(data_out), 0);
            end
        end
        chk("first_out_index", first_idx, 8);

        // Sparse input: valid every other cycle.
        for (int i = 0; i < 40; i++) cyc(1, 0, i % 2, rnd_data(), 0, 0);

        // Queue delay 3 mid-line, then apply at sol.
        cyc(1, 0, 1, rnd_data(), 1, 3);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, rnd_data(), 0, 0);
        chk("pend_before_sol", int'(active_delay), DEF_D);
        cyc(1, 1, 0, 0, 0, 0);
        chk("primed_after_sol", int'(primed), 0);
        for (int i = 0; i < 20; i++) cyc(1, 0, 1, rnd_data(), 0, 0);

        // Clamp of 0 to 1, with a last-wins overwrite.
        cyc(1, 0, 1, rnd_data(), 1, 7);
        cyc(1, 0, 1, rnd_data(), 1, 0);
        cyc(1, 1, 1, rnd_data(), 0, 0);
        chk("clamp_zero", int'(active_delay), 1);
        for (int i = 0; i < 20; i++) cyc(1, 0, $urandom_range(0, 3) != 0, rnd_data(), 0, 0);

        // Maximum delay with pointer wrap over 2500 samples.
        cyc(1, 0, 1, rnd_data(), 1, DEPTH - 1);
        cyc(1, 1, 1, rnd_data(), 0, 0);
        chk("clamp_max", int'(active_delay), DEPTH - 1);
        for (int i = 0; i < 2500; i++) cyc(1, 0, 1, rnd_data(), 0, 0);

        // cfg_load, sol and in_valid together: that sample is fill #1.
        captured = rnd_data();
        cyc(1, 1, 1, captured, 1, 5);
        chk("simul_delay", int'(active_delay), 5);
        chk("simul_pending", int'(cfg_pending), 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1, 0, 1, rnd_data(), 0, 0);
            if (out_valid) begin
                seen = 1;
                chk("simul_first_out", int'(unsigned'(data_out)), captured);
                chk("simul_first_pos", i, 4);
            end
        end
        chk("simul_out_seen", seen, 1);

        // Disable in RUN, queue a config while idle, then re-enable and apply.
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, rnd_data(), 0, 0);
        cyc(0, 0, 1, rnd_data(), 0, 0);
        chk("disable_ov", int'(out_valid), 0);
        cyc(0, 1, 1, rnd_data(), 1, 4);
        cyc(0, 1, 0, 0, 0, 0);
        chk("idle_pending_kept", int'(cfg_pending), 1);
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, rnd_data(), 0, 0);
        cyc(1, 1, 1, rnd_data(), 0, 0);
        chk("reenable_apply", int'(active_delay), 4);

        // Random mix of all controls.
        for (int i = 0; i < 1500; i++) begin
            int cd;
            cd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                             : int'($urandom_range(0, 20));
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 24) == 0,
                $urandom_range(0, 3) != 0,
                rnd_data(),
                $urandom_range(0, 29) == 0,
                cd);
        end

        // Asynchronous reset in the middle of RUN.
        cyc(1, 1, 1, rnd_data(), 1, 2);
        for (int i = 0; i < 6; i++) cyc(1, 0, 1, rnd_data(), 0, 0);
        cyc(1, 0, 1, rnd_data(), 1, 9);
        chk("pre_rst_primed", int'(primed), 1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_out_valid",    int'(out_valid), 0);
        chk("arst_data_out",     int'(data_out), 0);
        chk("arst_primed",       int'(primed), 0);
        chk("arst_cfg_pending",  int'(cfg_pending), 0);
        chk("arst_active_delay", int'(active_delay), DEF_D);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 30; i++) cyc(1, 0, 1, rnd_data(), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/delay_line_sched.md
Name: delay_line_sched

Overview:
- Sample-enabled, runtime-reconfigurable delay controller for the 12-bit signed video/sample datapath, run at the 74.25 MHz pixel clock.
- Owns an inferred circular buffer plus its write/read pointers, and sequences priming, steady state and reconfiguration.
- Output is the input stream delayed by D *accepted samples*, not D clock cycles.
- Delay changes are queued by software/control logic and take effect only at a start-of-line boundary, so lines are never torn.

Parameters:
- DATA_W, 12, sample width (signed).
- DEPTH, 1024, buffer entries; power of two.
- ADDR_W, 10, log2(DEPTH).
- DEFAULT_DELAY, 8, delay D loaded at reset.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  block enable; low holds IDLE.
- sol  in  1  start-of-line strobe, one cycle.
- in_valid  in  1  data_in is a new sample this cycle.
- data_in  in  DATA_W  signed input sample.
- cfg_load  in  1  request new delay; one-cycle strobe.
- cfg_delay  in  ADDR_W  requested delay, in samples.
- data_out  out  DATA_W  signed delayed sample.
- out_valid  out  1  data_out updated this cycle.
- primed  out  1  high while state == RUN.
- cfg_pending  out  1  a queued delay awaits the next sol.
- active_delay  out  ADDR_W  delay currently in force.

Behaviour:
- Reset (async, rst high):
  - state=IDLE; data_out=0, out_valid=0, primed=0, cfg_pending=0.
  - active_delay=DEFAULT_DELAY; wr_ptr=0, fill_cnt=0.
  - Buffer contents are not cleared.
- Delay clamp, applied at latch time:
  - requested 0 -> 1.
  - requested DEPTH-1 or more -> DEPTH-1.
  - Legal D range is therefore 1..DEPTH-1.
- States:
  - IDLE: in_valid and sol ignored. out_valid=0, data_out holds its last value. enable=1 -> FILL, with wr_ptr=0 and fill_cnt=0.
  - FILL: each in_valid writes data_in at wr_ptr, then wr_ptr++ (mod DEPTH) and fill_cnt++. out_valid stays 0. When fill_cnt reaches active_delay on a write, the next cycle is RUN.
  - RUN: each in_valid writes at wr_ptr and reads addr (wr_ptr - active_delay) mod DEPTH. Next cycle: data_out = read value, out_valid=1. No in_valid -> out_valid=0 and data_out holds.
  - Any state with enable=0 -> IDLE on the next edge. Any in-flight output is dropped: out_valid=0 from then on.
- Latency and ordering:
  - Output sample k (k >= D, counted from FILL entry) equals input sample k-D.
  - It appears exactly 1 cycle after input sample k's in_valid.
  - Read and write addresses never coincide, because D >= 1.
- Reconfiguration:
  - cfg_load latches clamp(cfg_delay) into pending_delay and sets cfg_pending=1 next cycle.
  - A second cfg_load before sol overwrites pending_delay (last wins).
  - On sol in FILL or RUN with cfg_pending=1: active_delay <= pending_delay, cfg_pending <= 0, state <= FILL, fill_cnt <= 0. wr_ptr is not reset.
  - sol with cfg_pending=0 has no effect.
- Simultaneous events:
  - cfg_load and sol in the same cycle: the new value is applied at that sol.
  - sol and in_valid in the same cycle: the reconfiguration applies first. That sample counts as fill sample 1 of the new FILL and produces no output.
  - enable=0 has priority over sol and cfg application. A pending config survives IDLE and is applied at the first sol after re-enable.
- Status outputs:
  - primed reflects the registered state.
  - active_delay updates on the cycle after the applying sol.

Test Plan:
- Reset, enable=1, in_valid every cycle, data_in=0,10,20,...,190 -> out_valid first high 1 cycle after the 9th sample (index 8); data_out sequence 0,10,20,...,110.
- in_valid every other cycle, D=8 -> out_valid pulses only in cycles following an in_valid; values delayed by 8 samples (not 8 cycles).
- cfg_load cfg_delay=3 mid-line -> cfg_pending=1, active_delay stays 8 until sol. At sol: primed=0, then 3 fill samples, then output = input delayed by 3.
- cfg_delay=0 -> active_delay=1. cfg_delay=1023 (DEPTH=1024) -> active_delay=1023. Run 2500 samples to cross pointer wrap -> no corrupted or missing samples.
- cfg_load with cfg_delay=5 and sol in the same cycle, with in_valid also high -> active_delay=5 next cycle. That sample is fill #1. First output equals it, 5 samples later.
- rst asserted mid-RUN, asynchronously between edges -> all outputs 0 immediately, state IDLE. enable=0 in RUN -> out_valid=0 next cycle and data_out holds.
